// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshake plus the shared 4x4 multiplier hookup for mul8_seq_ctrl.
// slave is the controller side; master is the requester/multiplier side.
interface mul8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_m;

    modport master (
        output in_valid, a, b, out_ready, mul_m,
        input  in_ready, out_valid, p, busy, mul_a, mul_b
    );

    modport slave (
        input  in_valid, a, b, out_ready, mul_m,
        output in_ready, out_valid, p, busy, mul_a, mul_b
    );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// Unsigned 8x8 multiply built from four passes through one shared external 4x4 multiplier.
// Partial products are shifted and summed into a 16-bit accumulator, result on valid/ready.
module mul8_seq_ctrl #(
    parameter int unsigned PIPE_MUL = 0
) (
    input logic           clk,
    input logic           rst_n,
    mul8_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMul, StWait, StDone} state_e;

    state_e      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [1:0]  step_q;
    logic [15:0] acc_q;
    logic [15:0] pp_q;
    logic [15:0] p_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [3:0]  mul_a_q;
    logic [3:0]  mul_b_q;

    logic [15:0] term;
    logic [15:0] acc_sum;
    logic [1:0]  step_nxt;
    logic [3:0]  mul_a_nxt;
    logic [3:0]  mul_b_nxt;

    // Step bit 0 selects the high multiplicand nibble, bit 1 the high multiplier nibble.
    always_comb begin
        term = 16'h0000;
        case (step_q)
            2'd0:    term = {8'h00, bus.mul_m};
            2'd1,
            2'd2:    term = {4'h0, bus.mul_m, 4'h0};
            default: term = {bus.mul_m, 8'h00};
        endcase
        acc_sum   = acc_q + ((PIPE_MUL != 0) ? pp_q : term);
        step_nxt  = step_q + 2'd1;
        mul_a_nxt = step_nxt[0] ? a_q[7:4] : a_q[3:0];
        mul_b_nxt = step_nxt[1] ? b_q[7:4] : b_q[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            step_q      <= 2'd0;
            acc_q       <= 16'h0000;
            pp_q        <= 16'h0000;
            p_q         <= 16'h0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_a_q     <= 4'h0;
            mul_b_q     <= 4'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= 16'h0000;
                        pp_q       <= 16'h0000;
                        step_q     <= 2'd0;
                        mul_a_q    <= bus.a[3:0];
                        mul_b_q    <= bus.b[3:0];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StMul;
                    end
                end
                StMul: begin
                    // In pipelined mode acc_sum adds the previous step's registered term.
                    acc_q  <= acc_sum;
                    pp_q   <= term;
                    step_q <= step_nxt;
                    if (step_q == 2'd3) begin
                        mul_a_q <= 4'h0;
                        mul_b_q <= 4'h0;
                        if (PIPE_MUL != 0) begin
                            state_q <= StWait;
                        end else begin
                            p_q         <= acc_sum;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end else begin
                        mul_a_q <= mul_a_nxt;
                        mul_b_q <= mul_b_nxt;
                    end
                end
                StWait: begin
                    acc_q       <= acc_sum;
                    p_q         <= acc_sum;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = busy_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl: one instance per PIPE_MUL setting, each with its own
// behavioural 4x4 multiplier, checked against hand-computed products and cycle counts.
module tb_mul8_seq_ctrl;

    logic clk;
    logic rst_n;

    mul8_seq_ctrl_if bus0 ();
    mul8_seq_ctrl_if bus1 ();

    logic [1:0]  in_valid_t;
    logic [1:0]  out_ready_t;
    logic [7:0]  a_t [2];
    logic [7:0]  b_t [2];

    logic [1:0]  in_ready_o;
    logic [1:0]  out_valid_o;
    logic [1:0]  busy_o;
    logic [15:0] p_o [2];
    logic [3:0]  mul_a_o [2];
    logic [3:0]  mul_b_o [2];

    int n_vec;
    int n_miss;

    assign bus0.in_valid  = in_valid_t[0];
    assign bus0.out_ready = out_ready_t[0];
    assign bus0.a         = a_t[0];
    assign bus0.b         = b_t[0];
    assign bus0.mul_m     = {4'h0, bus0.mul_a} * {4'h0, bus0.mul_b};
    assign bus1.in_valid  = in_valid_t[1];
    assign bus1.out_ready = out_ready_t[1];
    assign bus1.a         = a_t[1];
    assign bus1.b         = b_t[1];
    assign bus1.mul_m     = {4'h0, bus1.mul_a} * {4'h0, bus1.mul_b};

    assign in_ready_o  = {bus1.in_ready, bus0.in_ready};
    assign out_valid_o = {bus1.out_valid, bus0.out_valid};
    assign busy_o      = {bus1.busy, bus0.busy};
    assign p_o[0]      = bus0.p;
    assign p_o[1]      = bus1.p;
    assign mul_a_o[0]  = bus0.mul_a;
    assign mul_a_o[1]  = bus1.mul_a;
    assign mul_b_o[0]  = bus0.mul_b;
    assign mul_b_o[1]  = bus1.mul_b;

    mul8_seq_ctrl #(.PIPE_MUL(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mul8_seq_ctrl #(.PIPE_MUL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input int sel, input logic [15:0] pexp);
        check("in_ready_idle", {31'd0, in_ready_o[sel]}, 32'd1);
        check("out_valid_idle", {31'd0, out_valid_o[sel]}, 32'd0);
        check("busy_idle", {31'd0, busy_o[sel]}, 32'd0);
        check("p_idle", {16'd0, p_o[sel]}, {16'd0, pexp});
        check("mul_idle", {24'd0, mul_a_o[sel], mul_b_o[sel]}, 32'd0);
    endtask

    // Latency k means out_valid is first seen high by edge k after the accept edge.
    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] pexp, input int lat_exp, input int stall,
                          input bit poke, output logic [31:0] seq);
        int lat;
        @(negedge clk);
        check("in_ready_pre", {31'd0, in_ready_o[sel]}, 32'd1);
        a_t[sel]         = av;
        b_t[sel]         = bv;
        in_valid_t[sel]  = 1'b1;
        out_ready_t[sel] = (stall == 0);
        @(posedge clk);
        #1;
        in_valid_t[sel] = 1'b0;
        lat = 0;
        seq = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 4) seq = {seq[23:0], mul_a_o[sel], mul_b_o[sel]};
            if (k == 1) check("busy_run", {31'd0, busy_o[sel]}, 32'd1);
            if (poke && k == 2) begin
                in_valid_t[sel] = 1'b1;
                a_t[sel]        = 8'h77;
                b_t[sel]        = 8'h77;
            end
            if (poke && k == 3) in_valid_t[sel] = 1'b0;
            if (out_valid_o[sel]) begin
                lat = k;
                break;
            end
        end
        in_valid_t[sel] = 1'b0;
        check("latency", lat, lat_exp);
        check("product", {16'd0, p_o[sel]}, {16'd0, pexp});
        check("mul_done_zero", {24'd0, mul_a_o[sel], mul_b_o[sel]}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            check("in_ready_stall", {31'd0, in_ready_o[sel]}, 32'd0);
            @(negedge clk);
            check("out_valid_hold", {31'd0, out_valid_o[sel]}, 32'd1);
            check("p_hold", {16'd0, p_o[sel]}, {16'd0, pexp});
        end
        out_ready_t[sel] = 1'b1;
        @(negedge clk);
        check_idle(sel, pexp);
    endtask

    // Hold in_valid and out_ready high and measure the spacing between accepts.
    task automatic tput(input int sel, input int period_exp);
        int n_acc;
        int last;
        n_acc = 0;
        last  = 0;
        @(negedge clk);
        a_t[sel]         = 8'h12;
        b_t[sel]         = 8'h34;
        in_valid_t[sel]  = 1'b1;
        out_ready_t[sel] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready_o[sel]) begin
                if (n_acc > 0) check("period", c - last, period_exp);
                last = c;
                n_acc++;
                if (n_acc == 3) break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid_t[sel] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready_o[sel]) break;
        end
        check("tput_ops", n_acc, 3);
        check("tput_p", {16'd0, p_o[sel]}, 32'h0000_03A8);
        check("tput_idle", {31'd0, in_ready_o[sel]}, 32'd1);
    endtask

    initial begin
        logic [31:0] seq;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        in_valid_t  = 2'b00;
        out_ready_t = 2'b00;
        a_t[0] = 8'h00; a_t[1] = 8'h00;
        b_t[0] = 8'h00; b_t[1] = 8'h00;
        repeat (2) @(negedge clk);
        check_idle(0, 16'h0000);
        check_idle(1, 16'h0000);
        rst_n = 1'b1;

        // Unpipelined instance.
        run_op(0, 8'h12, 8'h34, 16'h03A8, 5, 0, 1'b0, seq);
        check("mul_seq", seq, 32'h2414_2313);
        run_op(0, 8'hFF, 8'hFF, 16'hFE01, 5, 0, 1'b0, seq);
        run_op(0, 8'h00, 8'hB7, 16'h0000, 5, 0, 1'b0, seq);
        run_op(0, 8'h01, 8'hFF, 16'h00FF, 5, 0, 1'b0, seq);
        run_op(0, 8'hA5, 8'h5A, 16'h3A02, 5, 3, 1'b0, seq);
        run_op(0, 8'h12, 8'h34, 16'h03A8, 5, 0, 1'b1, seq);
        tput(0, 6);

        // Reset in the middle of 0xFF*0xFF, while step 2 is on the multiplier.
        @(negedge clk);
        a_t[0] = 8'hFF;
        b_t[0] = 8'hFF;
        in_valid_t[0]  = 1'b1;
        out_ready_t[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_t[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_step2", {24'd0, mul_a_o[0], mul_b_o[0]}, 32'h0000_00FF);
        rst_n = 1'b0;
        #1;
        check_idle(0, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_valid_after_rst", {31'd0, out_valid_o[0]}, 32'd0);
        check_idle(0, 16'h0000);
        run_op(0, 8'h03, 8'h05, 16'h000F, 5, 0, 1'b0, seq);

        // Pipelined instance.
        run_op(1, 8'h12, 8'h34, 16'h03A8, 6, 0, 1'b0, seq);
        check("mul_seq_pipe", seq, 32'h2414_2313);
        run_op(1, 8'hFF, 8'hFF, 16'hFE01, 6, 0, 1'b0, seq);
        run_op(1, 8'hA5, 8'h5A, 16'h3A02, 6, 3, 1'b0, seq);
        tput(1, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
